baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 90 +++++++++
 tb/tb_baud_gen_frac.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: divisor down-counter with a fractional carry accumulator,
// producing an oversample tick, a once-per-bit baud tick and a 50% duty baud square wave.
module baud_gen_frac #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ld,
    input  logic [7:0]        dll,
    input  logic [DIV_W-9:0]  dlh,
    input  logic [FRAC_W-1:0] dlf,
    output logic              tick,
    output logic              baud_tick,
    output logic              br,
    output logic              div_zero
);

    localparam int CNT_W = DIV_W + 1;
    localparam int SUB_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVS / 2 - 1);

    logic [DIV_W-1:0]  ds_q, ds_d;
    logic [FRAC_W-1:0] fs_q, fs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              br_q, br_d;

    logic [DIV_W-1:0]  d_in;
    logic [FRAC_W:0]   frac_sum;

    assign d_in      = {dlh, dll};
    assign div_zero  = (ds_q == '0);
    assign tick      = en && !div_zero && (cnt_q == '0);
    assign baud_tick = tick && (sub_q == SUB_LAST);
    assign br        = br_q;
    assign frac_sum  = {1'b0, acc_q} + {1'b0, fs_q};

    always_comb begin
        ds_d  = ds_q;
        fs_d  = fs_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        sub_d = sub_q;
        br_d  = br_q;
        // A load restarts the period even if the current cycle is a tick; the tick is dropped.
        if (ld) begin
            ds_d  = d_in;
            fs_d  = dlf;
            cnt_d = {1'b0, d_in} - CNT_W'(1);
            acc_d = '0;
            sub_d = '0;
            br_d  = 1'b0;
        end else if (en && !div_zero) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                acc_d = frac_sum[FRAC_W-1:0];
                cnt_d = {1'b0, ds_q} - CNT_W'(1) + CNT_W'(frac_sum[FRAC_W]);
                sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
                if (sub_q == SUB_HALF || sub_q == SUB_LAST) begin
                    br_d = ~br_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_q  <= '0;
            fs_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            sub_q <= '0;
            br_q  <= 1'b0;
        end else begin
            ds_q  <= ds_d;
            fs_q  <= fs_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            sub_q <= sub_d;
            br_q  <= br_d;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: tick schedule model from cumulative period sums,
// checked every cycle, plus directed scenarios with hand-computed timings.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              ld = 1'b0;
    logic [7:0]        dll = '0;
    logic [DIV_W-9:0]  dlh = '0;
    logic [FRAC_W-1:0] dlf = '0;
    logic              tick, baud_tick, br, div_zero;

    baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ld(ld),
        .dll(dll), .dlh(dlh), .dlf(dlf),
        .tick(tick), .baud_tick(baud_tick), .br(br), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tick n lands on enabled edge S(n) = n*D + floor((n-1)*F / 2^FRAC_W) after the load.
    longint m_ds = 0, m_fs = 0, m_e = 0, m_t = 0;

    function automatic longint s_of(input longint n);
        return n * m_ds + (((n - 1) * m_fs) >> FRAC_W);
    endfunction

    function automatic bit m_due();
        return (m_ds != 0) && (m_e + 1 == s_of(m_t + 1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ds = 0; m_fs = 0; m_e = 0; m_t = 0;
        end else if (ld) begin
            m_ds = {dlh, dll};
            m_fs = dlf;
            m_e  = 0;
            m_t  = 0;
        end else if (en && m_ds != 0) begin
            if (m_due()) m_t++;
            m_e++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (cmp_on) begin
            bit exp_tick;
            exp_tick = en && m_due();
            check("tick", tick, exp_tick);
            check("baud_tick", baud_tick, exp_tick && (m_t % OVS == OVS - 1));
            check("br", br, (m_t % OVS) >= OVS / 2);
            check("div_zero", div_zero, m_ds == 0);
        end
    end

    task automatic do_ld_now(input int d, input int f);
        ld  = 1'b1;
        dll = d[7:0];
        dlh = d[DIV_W-1:8];
        dlf = f[FRAC_W-1:0];
        @(negedge clk);
        ld  = 1'b0;
    endtask

    task automatic do_ld(input int d, input int f);
        @(negedge clk);
        do_ld_now(d, f);
    endtask

    // Called at the first negedge after a load edge; returns clocks from the load edge to the n-th event.
    task automatic measure(input bit use_baud, input int n, output int clks);
        int got = 0;
        clks = -1;
        for (int c = 1; c <= 3000; c++) begin
            #2;
            if (use_baud ? baud_tick : tick) begin
                got++;
                if (got == n) begin
                    clks = c;
                    return;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        repeat (100) @(negedge clk);
        #2;
        check("idle_tick", tick, 0);
        check("idle_br", br, 0);
        check("idle_div_zero", div_zero, 1);

        do_ld(4, 0);
        measure(0, 1, c);
        check("d4_first_tick_clk", c, 4);
        do_ld(4, 0);
        measure(1, 1, c);
        check("d4_first_baud_clk", c, 64);
        do_ld(4, 0);
        measure(0, 8, c);
        check("d4_tick8_clk", c, 32);
        @(negedge clk);
        #2;
        check("d4_br_high_after_8", br, 1);

        do_ld(4, 8);
        measure(0, 3, c);
        check("d4f8_tick3_clk", c, 13);
        do_ld(4, 8);
        measure(0, 33, c);
        check("d4f8_tick33_clk", c, 148);

        @(negedge clk);
        dll = 8'd9;
        dlf = 4'd1;
        repeat (50) @(negedge clk);

        do_ld(9, 15);
        measure(0, 3, c);
        check("d9f15_tick3_clk", c, 28);
        do_ld(258, 5);
        repeat (600) @(negedge clk);

        do_ld(1, 0);
        repeat (10) @(negedge clk);
        en = 1'b0;
        #2;
        check("d1_pause_tick", tick, 0);
        check("d1_pause_br", br, 1);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("d1_resume_baud", baud_tick, 1);

        do_ld(3, 0);
        repeat (5) @(negedge clk);
        #2;
        check("d3_tick_before_reload", tick, 1);
        do_ld_now(6, 0);
        measure(0, 1, c);
        check("reload_d6_tick_clk", c, 6);
        check("reload_d6_br", br, 0);

        do_ld(0, 3);
        repeat (20) @(negedge clk);
        #2;
        check("d0_div_zero", div_zero, 1);
        check("d0_tick", tick, 0);

        do_ld(4, 0);
        repeat (40) @(negedge clk);
        #3;
        check("pre_reset_br", br, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_br", br, 0);
        check("async_reset_div_zero", div_zero, 1);
        check("async_reset_tick", tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("post_reset_div_zero", div_zero, 1);
        do_ld(5, 3);
        measure(0, 2, c);
        check("d5f3_tick2_clk", c, 10);

        repeat (2) @(negedge clk);
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
